// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and multi-cycle mul/div hold with timeout.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_count performance counter outputs.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic       fwd_stall,
    input  logic       br_taken,
    input  logic       md_start,
    input  logic       md_done,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exma_bubble,
    output logic       md_busy,
    output logic       md_timeout_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MD_DRAIN = 2'd2
    } state_e;

    localparam int unsigned     TO_W   = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MD_TIMEOUT);

    if (MD_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("hazard_ctrl: MD_TIMEOUT and CNT_W must both be at least 1");
    end

    state_e          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_cnt_inc;
    logic            to_hit;
    logic            err_q, err_d;
    logic            lu;

    always_comb begin
        lu = idex_mem_read && (idex_rd != 5'd0) &&
             ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
        to_cnt_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        // "Reaches" means the count after this busy cycle's increment.
        to_hit = (to_cnt_inc == TO_MAX);

        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exma_bubble = 1'b0;
        md_busy     = 1'b0;

        case (state_q)
            RUN: begin
                if (br_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    if (fwd_stall) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exma_bubble = 1'b1;
                    end else if (lu) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                    if (md_start) begin
                        state_d  = MD_BUSY;
                        to_cnt_d = '0;
                    end
                end
            end
            MD_BUSY: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exma_bubble = 1'b1;
                md_busy     = 1'b1;
                to_cnt_d    = to_cnt_inc;
                if (md_done) begin
                    state_d = MD_DRAIN;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = MD_DRAIN;
                end
            end
            MD_DRAIN: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign md_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    // Free-running counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (ifid_flush) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

    localparam int MD_TO = 8;

    logic       clk;
    logic       rstn;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       idex_mem_read, fwd_stall, br_taken, md_start, md_done;
    logic       pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush;
    logic       exma_bubble, md_busy, md_timeout_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(32)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .fwd_stall      (fwd_stall),
        .br_taken       (br_taken),
        .md_start       (md_start),
        .md_done        (md_done),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .idex_stall     (idex_stall),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exma_bubble    (exma_bubble),
        .md_busy        (md_busy),
        .md_timeout_err (md_timeout_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] act_vec;
    assign act_vec = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
                      exma_bubble, md_busy, md_timeout_err};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mul/div progress tracked as elapsed busy cycles.
    bit          m_busy, m_drain, m_err;
    int          m_elapsed;
    int unsigned m_stalls, m_flushes;

    function automatic logic [7:0] model_out();
        logic       lu_c;
        logic [7:0] o;
        o    = 8'h00;
        lu_c = idex_mem_read && (idex_rd != 5'd0) &&
               ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
        if (m_busy) begin
            o[7:1] = 7'b1110011;
        end else if (!m_drain) begin
            if (br_taken)       o[4:3] = 2'b11;
            else if (fwd_stall) o[7:2] = 6'b111001;
            else if (lu_c)      o[7:3] = 5'b11001;
        end
        o[0] = m_err;
        return o;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy    <= 1'b0;
            m_drain   <= 1'b0;
            m_err     <= 1'b0;
            m_elapsed <= 0;
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            logic [7:0] o;
            o = model_out();
            if (o[7]) m_stalls  <= m_stalls + 1;
            if (o[4]) m_flushes <= m_flushes + 1;
            if (m_busy) begin
                m_elapsed <= m_elapsed + 1;
                if (md_done || (m_elapsed + 1 >= MD_TO)) begin
                    if (!md_done) m_err <= 1'b1;
                    m_busy  <= 1'b0;
                    m_drain <= 1'b1;
                end
            end else if (m_drain) begin
                m_drain <= 1'b0;
            end else if (md_start && !br_taken) begin
                m_busy    <= 1'b1;
                m_elapsed <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", {24'h0, act_vec}, {24'h0, model_out()});
`ifdef HAZARD_PERF_EN
            check("cycle_stall_cycles", stall_cycles, m_stalls);
            check("cycle_flush_count", flush_count, m_flushes);
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
        idex_mem_read = 1'b0; fwd_stall = 1'b0; br_taken = 1'b0;
        md_start = 1'b0; md_done = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        idex_mem_read = 1'b1; idex_rd = rd; ifid_rs2 = rd;
    endtask

    // Launch mul/div, pulse md_done on busy cycle done_at (0 = never); returns at mid of the drain cycle.
    task automatic md_op(input int done_at, input bit noise, output int nbusy);
        nbusy    = 0;
        md_start = 1'b1;
        next_cycle();
        for (int i = 0; i < 40; i++) begin
            md_start = noise;
            mid();
            if (!md_busy) break;
            nbusy++;
            md_done = (nbusy == done_at);
            next_cycle();
            md_done = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr();
        rstn = 1'b0;
        #1;
        check("reset_outputs", {24'h0, act_vec}, 32'h00);
        next_cycle();
        next_cycle();
        rstn   = 1'b1;
        chk_en = 1'b1;

        set_lu(5'd5);
        mid();  check("lu_stall", {24'h0, act_vec}, 32'hC8);
        next_cycle(); clr();
        mid();  check("lu_one_cycle", {24'h0, act_vec}, 32'h00);

        next_cycle(); set_lu(5'd0);
        mid();  check("lu_x0_no_stall", {24'h0, act_vec}, 32'h00);

        next_cycle(); clr();
        idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; fwd_stall = 1'b1;
        mid();  check("fwd_over_lu", {24'h0, act_vec}, 32'hE4);

        next_cycle(); clr(); set_lu(5'd5); br_taken = 1'b1;
        mid();  check("br_over_lu", {24'h0, act_vec}, 32'h18);

        next_cycle(); clr(); br_taken = 1'b1; md_start = 1'b1;
        mid();  check("br_cancels_md", {24'h0, act_vec}, 32'h18);
        next_cycle(); clr(); md_done = 1'b1;
        mid();  check("no_busy_after_cancel", {24'h0, act_vec}, 32'h00);

        next_cycle(); clr();
        md_op(5, 1'b0, n);
        check("md_busy_len", n, 5);
        check("md_drain_zero", {24'h0, act_vec}, 32'h00);
        next_cycle(); set_lu(5'd3);
        mid();  check("run_after_drain", {24'h0, act_vec}, 32'hC8);

        next_cycle(); clr();
        md_op(MD_TO, 1'b1, n);
        check("md_done_at_limit_len", n, MD_TO);
        check("md_done_at_limit_no_err", {31'h0, md_timeout_err}, 32'h0);

        next_cycle(); clr();
        md_op(0, 1'b0, n);
        check("timeout_len", n, MD_TO);
        check("timeout_drain_err", {24'h0, act_vec}, 32'h01);
        next_cycle(); clr();
        mid();  check("err_sticky_run", {24'h0, act_vec}, 32'h01);
        next_cycle();
        md_op(3, 1'b0, n);
        check("err_sticky_md_len", n, 3);
        check("err_sticky_md", {31'h0, md_timeout_err}, 32'h1);

        next_cycle(); clr();
        md_start = 1'b1;
        next_cycle(); md_start = 1'b0;
        next_cycle();
        next_cycle();
        mid();  check("busy_cycle3", {31'h0, md_busy}, 32'h1);
        rstn = 1'b0;
        #1;
        check("async_rst_md_busy", {31'h0, md_busy}, 32'h0);
        check("async_rst_pc_stall", {31'h0, pc_stall}, 32'h0);
        check("rst_clears_err", {31'h0, md_timeout_err}, 32'h0);
        next_cycle();
        next_cycle();
        rstn = 1'b1;

        set_lu(5'd9);                 mid(); next_cycle(); clr();
        mid(); next_cycle();
        br_taken = 1'b1;              mid(); next_cycle(); clr();
        set_lu(5'd9);                 mid(); next_cycle(); clr();
        br_taken = 1'b1;              mid(); next_cycle(); clr();
        set_lu(5'd9);                 mid(); next_cycle(); clr();
        mid();
        check("idle_after_rst", {24'h0, act_vec}, 32'h00);
`ifdef HAZARD_PERF_EN
        check("perf_stall_cycles", stall_cycles, 32'd3);
        check("perf_flush_count", flush_count, 32'd2);
`endif
        next_cycle();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64: max cycles in MD_BUSY before the timeout error is flagged.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ifid_rs1, ifid_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port idex_mem_read  input  1  the instruction in EX is a load.
REQ-007 SHALL have port idex_rd  input  5  destination register of the instruction in EX.
REQ-008 SHALL have port fwd_stall  input  1  forward unit selected code 5 (EX operand not yet forwardable).
REQ-009 SHALL have port br_taken  input  1  taken branch/jump resolved in EX.
REQ-010 SHALL have ports md_start, md_done  input  1 each  multi-cycle mul/div launch (EX) and completion pulse.
REQ-011 SHALL have ports pc_stall, ifid_stall, idex_stall  output  1 each  hold the PC and the IF/ID and ID/EX registers.
REQ-012 SHALL have ports ifid_flush, idex_flush, exma_bubble  output  1 each  zero the IF/ID and ID/EX registers and insert a NOP into EX/MA.
REQ-013 SHALL have port md_busy  output  1  high while the FSM is in MD_BUSY.
REQ-014 SHALL have port md_timeout_err  output  1  sticky timeout error.

Function
REQ-015 SHALL implement states RUN, MD_BUSY and MD_DRAIN, encoded in 2 bits.
REQ-016 SHALL define load-use (lu) = idex_mem_read && idex_rd!=0 && (idex_rd==ifid_rs1 || idex_rd==ifid_rs2).
REQ-017 SHALL, in RUN with br_taken=1, assert ifid_flush=1 and idex_flush=1 in the same cycle, suppress lu and fwd_stall actions, and remain in RUN.
REQ-018 SHALL, in RUN with fwd_stall=1 and br_taken=0, assert pc_stall, ifid_stall, idex_stall and exma_bubble for that cycle; this action takes priority over lu.
REQ-019 SHALL, in RUN with lu=1, br_taken=0 and fwd_stall=0, assert pc_stall, ifid_stall and idex_flush for exactly that cycle.
REQ-020 SHALL, in RUN with md_start=1 and br_taken=0, go to MD_BUSY on the next edge and clear the timeout counter; br_taken=1 cancels the launch.
REQ-021 SHALL, in MD_BUSY, assert pc_stall, ifid_stall, idex_stall, exma_bubble and md_busy, and increment the timeout counter (saturating at MD_TIMEOUT).
REQ-022 SHALL, in MD_BUSY, go to MD_DRAIN on md_done=1; md_done in the cycle the counter reaches MD_TIMEOUT wins and no error is raised.
REQ-023 SHALL, when the counter equals MD_TIMEOUT and md_done=0, set md_timeout_err and go to MD_DRAIN.
REQ-024 SHALL, in MD_DRAIN, hold all stall, flush and bubble outputs at 0 for one cycle, then go to RUN; the instruction after mul/div then advances.
REQ-025 SHALL ignore md_done in RUN and md_start outside RUN.
REQ-026 SHALL keep md_timeout_err set until reset.

Reset
REQ-027 SHALL, on rstn=0, immediately (asynchronously) enter RUN and clear the timeout counter, md_timeout_err and the performance counters.
REQ-028 SHALL, while in reset with all inputs at 0, drive every output to 0.
REQ-029 SHALL, when reset is asserted mid-MD_BUSY, drop all stalls at once; no drain cycle follows.

Configuration
REQ-030 SHALL honour macro HAZARD_PERF_EN: when defined, add output stall_cycles (CNT_W), counting cycles with pc_stall=1, and output flush_count (CNT_W), counting cycles with ifid_flush=1.
REQ-031 SHALL let both counters wrap at 2^CNT_W.
REQ-032 SHALL, without HAZARD_PERF_EN, omit both counters and their ports entirely, with the port list otherwise identical.

Verification
REQ-033 Load-use: idex_mem_read=1, idex_rd=5, ifid_rs2=5 for one cycle -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle; same stimulus with idex_rd=0 -> no stall.
REQ-034 Branch vs lu: br_taken=1 together with the lu condition -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-035 Mul/div: md_start pulse, md_done after 10 cycles -> md_busy high for 10 cycles, then 1 drain cycle with all outputs 0, then RUN.
REQ-036 Timeout: MD_TIMEOUT=8, md_start with no md_done -> md_timeout_err=1 after 8 busy cycles, FSM returns to RUN, err stays 1 until rstn=0.
REQ-037 Reset mid-op: rstn=0 on busy cycle 3 -> md_busy and pc_stall go to 0 before the next clk edge.
REQ-038 Perf counters (HAZARD_PERF_EN defined): 3 lu stalls and 2 branches -> stall_cycles=3, flush_count=2.
